// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//  Pipeline sequencing controller for the 5-stage core. It compares the
//  instruction sitting in ID against a 3-entry scoreboard of in-flight
//  instructions (EX, MEM, WB). From that comparison it produces:
//    * PC/IF-ID freeze and ID/EX bubble on a data hazard,
//    * IF/ID flush for FLUSH_CYCLES cycles after a taken branch,
//    * registered EX operand forwarding selects.
//
//  Handshake/timing contract: there is no valid/ready pair here. id_valid
//  qualifies the ID instruction for the current cycle only. The instruction
//  "issues" (enters the EX scoreboard slot) on a rising clk edge when
//  id_valid=1, stall_pc=0 and flush_ifid=0. While stall_pc=1 the IF stage
//  must hold the same instruction in ID.
//
//  Ports
//    clk, rst          rising-edge clock, asynchronous active-low reset
//    id_valid          ID holds a real instruction
//    id_src1/id_src2   ID source registers
//    id_uses_src2      src2 is read as an operand
//    id_wb_en/id_dest  ID instruction writes id_dest
//    id_mem_read       ID instruction is a load
//    br_taken          branch resolved taken in EX this cycle
//    stall_pc          hold PC and IF/ID          (combinational)
//    bubble_ex         load NOP into ID/EX        (combinational)
//    flush_ifid        clear IF/ID                (combinational)
//    fwd_a/fwd_b       EX operand select, 00 reg / 01 MEM / 10 WB (registered)
//    stat_stall        saturating count of stall_pc cycles
//    dbg_flushing      flush FSM is in its FLUSH state
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter bit          FORWARD_EN   = 1'b1,
   parameter bit          RF_BYPASS    = 1'b1,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_src1,
   input  logic [4:0]  id_src2,
   input  logic        id_uses_src2,
   input  logic        id_wb_en,
   input  logic [4:0]  id_dest,
   input  logic        id_mem_read,
   input  logic        br_taken,
   output logic        stall_pc,
   output logic        bubble_ex,
   output logic        flush_ifid,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [15:0] stat_stall,
   output logic        dbg_flushing
);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   // Only the EX slot needs mem_read: load-use is the one hazard that
   // forwarding cannot cover.
   typedef struct packed {
      logic       wb_en;
      logic [4:0] dest;
      logic       mem_read;
   } ex_entry_t;

   typedef struct packed {
      logic       wb_en;
      logic [4:0] dest;
   } sb_entry_t;

   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

   ex_entry_t   ex_q,  ex_d;
   sb_entry_t   mem_q, mem_d;
   sb_entry_t   wb_q,  wb_d;
   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  fwd_a_q, fwd_a_d;
   logic [1:0]  fwd_b_q, fwd_b_d;
   logic [15:0] stat_q, stat_d;

   logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
   logic hazard, flush_act, stall, issue;

   // Register 0 is hard-wired zero and never creates a dependency.
   function automatic logic hits(input logic wb_en, input logic [4:0] dest,
                                 input logic [4:0] s);
      return wb_en && (dest == s) && (s != 5'd0);
   endfunction

   always_comb begin
      ex_hit_a  = id_valid && hits(ex_q.wb_en, ex_q.dest, id_src1);
      ex_hit_b  = id_valid && id_uses_src2 && hits(ex_q.wb_en, ex_q.dest, id_src2);
      mem_hit_a = id_valid && hits(mem_q.wb_en, mem_q.dest, id_src1);
      mem_hit_b = id_valid && id_uses_src2 && hits(mem_q.wb_en, mem_q.dest, id_src2);
      wb_hit_a  = id_valid && hits(wb_q.wb_en, wb_q.dest, id_src1);
      wb_hit_b  = id_valid && id_uses_src2 && hits(wb_q.wb_en, wb_q.dest, id_src2);

      if (FORWARD_EN) begin
         hazard = (ex_hit_a || ex_hit_b) && ex_q.mem_read;
      end else begin
         hazard = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b ||
                  (!RF_BYPASS && (wb_hit_a || wb_hit_b));
      end

      // A taken branch overrides a hazard: the ID instruction is wrong-path.
      flush_act = br_taken || (state_q == ST_FLUSH);
      stall     = hazard && !flush_act;
      issue     = id_valid && !stall && !flush_act;
   end

   always_comb begin
      ex_d  = issue ? '{wb_en: id_wb_en, dest: id_dest, mem_read: id_mem_read} : '0;
      mem_d = '{wb_en: ex_q.wb_en, dest: ex_q.dest};
      wb_d  = mem_q;

      // Youngest producer wins: EX slot (will be in MEM) before MEM slot (will be in WB).
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
      if (FORWARD_EN && issue) begin
         if (ex_hit_a)       fwd_a_d = 2'b01;
         else if (mem_hit_a) fwd_a_d = 2'b10;
         if (ex_hit_b)       fwd_b_d = 2'b01;
         else if (mem_hit_b) fwd_b_d = 2'b10;
      end

      stat_d = (stall && (stat_q != 16'hFFFF)) ? stat_q + 16'd1 : stat_q;
   end

   // Flush FSM: the br_taken cycle flushes by itself; FLUSH covers the
   // remaining FLUSH_CYCLES-1 cycles, and a new br_taken restarts the count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (br_taken && MULTI_FLUSH) begin
               state_d = ST_FLUSH;
               cnt_d   = FLUSH_RELOAD;
            end
         end
         ST_FLUSH: begin
            if (br_taken) begin
               cnt_d = FLUSH_RELOAD;
            end else if (cnt_q == 3'd1) begin
               state_d = ST_RUN;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         state_q <= ST_RUN;
         cnt_q   <= 3'd0;
         fwd_a_q <= 2'b00;
         fwd_b_q <= 2'b00;
         stat_q  <= 16'd0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         stat_q  <= stat_d;
      end
   end

   assign stall_pc     = stall;
   assign bubble_ex    = stall;
   assign flush_ifid   = flush_act;
   assign fwd_a        = fwd_a_q;
   assign fwd_b        = fwd_b_q;
   assign stat_stall   = stat_q;
   assign dbg_flushing = (state_q == ST_FLUSH);

endmodule
